// File: rtl/dot_prod_pkg.sv
// Shared constants and FSM encoding for the dot-product host and its kernel.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dot_prod_pkg;

    localparam int ARR_LEN = 1000;
    localparam int ADDR_W  = 10;
    localparam int ELEM_W  = 27;
    localparam int ACC_W   = 64;
    localparam int CNT_W   = 11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FILL,
        START,
        RUN,
        HOLD
    } state_t;

endpackage

// File: rtl/dot_prod_host.sv
// Loads an element-pair vector into the kernel arrays, zero-pads to ARR_LEN, starts the kernel, returns its result.
// Latency: ARR_LEN+1 cycles from first accepted pair to r_enable; result one cycle after w_enable.
// Backpressure: in_ready drops outside IDLE/LOAD; result held in HOLD until res_ready.
module dot_prod_host #(
    parameter int ARR_LEN = dot_prod_pkg::ARR_LEN,
    parameter int ADDR_W  = dot_prod_pkg::ADDR_W,
    parameter int ELEM_W  = dot_prod_pkg::ELEM_W,
    parameter int ACC_W   = dot_prod_pkg::ACC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [ELEM_W-1:0] in_a,
    input  logic signed [ELEM_W-1:0] in_b,
    input  logic                     in_last,
    input  logic signed [ACC_W-1:0]  acc_bias,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [ACC_W-1:0]  res_data,
    output logic [10:0]              res_count,
    output logic                     controlArr,
    output logic                     r_enable,
    output logic [ADDR_W-1:0]        init_i,
    output logic signed [ACC_W-1:0]  init_acc,
    output logic                     controlArrWEnable_a,
    output logic                     controlArrWEnable_b,
    output logic [ADDR_W-1:0]        controlArrAddr_a,
    output logic [ADDR_W-1:0]        controlArrAddr_b,
    output logic signed [ELEM_W-1:0] controlArrWData_a,
    output logic signed [ELEM_W-1:0] controlArrWData_b,
    input  logic                     w_enable,
    input  logic signed [ACC_W-1:0]  result
);
    import dot_prod_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ARR_LEN - 1);

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]   bias_q, bias_d;
    logic signed [ACC_W-1:0]   res_data_q, res_data_d;
    logic [10:0]               res_count_q, res_count_d;

    logic                      accept;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic signed [ELEM_W-1:0]  wr_a;
    logic signed [ELEM_W-1:0]  wr_b;

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            bias_q      <= '0;
            res_data_q  <= '0;
            res_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            bias_q      <= bias_d;
            res_data_q  <= res_data_d;
            res_count_q <= res_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bias_d      = bias_q;
        res_data_d  = res_data_q;
        res_count_d = res_count_q;
        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    if (state_q == IDLE) bias_d = acc_bias;
                    state_d = LOAD;
                    idx_d   = idx_q + 1'b1;
                    // A last flag on the final address is the same end-of-vector, not a second one.
                    if (in_last || idx_q == LAST_IDX) begin
                        res_count_d = 11'(idx_q) + 11'd1;
                        if (idx_q == LAST_IDX) begin
                            state_d = START;
                            idx_d   = idx_q;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end
            end
            FILL: begin
                if (idx_q == LAST_IDX) state_d = START;
                else                   idx_d   = idx_q + 1'b1;
            end
            START: state_d = RUN;
            RUN: begin
                if (w_enable) begin
                    res_data_d = result;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gated by rst_n so the array ports and handshakes go quiet the moment reset asserts.
    always_comb begin
        in_ready   = 1'b0;
        controlArr = 1'b0;
        r_enable   = 1'b0;
        init_acc   = '0;
        res_valid  = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_a       = '0;
        wr_b       = '0;
        if (rst_n) begin
            case (state_q)
                IDLE, LOAD: begin
                    in_ready   = 1'b1;
                    controlArr = 1'b1;
                    if (in_valid) begin
                        wr_en   = 1'b1;
                        wr_addr = idx_q;
                        wr_a    = in_a;
                        wr_b    = in_b;
                    end
                end
                FILL: begin
                    controlArr = 1'b1;
                    wr_en      = 1'b1;
                    wr_addr    = idx_q;
                end
                START: begin
                    r_enable = 1'b1;
                    init_acc = bias_q;
                end
                HOLD:    res_valid = 1'b1;
                default: ;
            endcase
        end
    end

    assign controlArrWEnable_a = wr_en;
    assign controlArrWEnable_b = wr_en;
    assign controlArrAddr_a    = wr_addr;
    assign controlArrAddr_b    = wr_addr;
    assign controlArrWData_a   = wr_a;
    assign controlArrWData_b   = wr_b;
    assign init_i              = '0;
    assign res_data            = res_data_q;
    assign res_count           = res_count_q;

endmodule

// File: tb/tb_dot_prod_host.sv
// Bench for dot_prod_host with a behavioural kernel that owns the two arrays.
module tb_dot_prod_host;

    typedef struct {
        longint data;
        int     cnt;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [26:0] in_a = '0;
    logic signed [26:0] in_b = '0;
    logic               in_last = 1'b0;
    logic signed [63:0] acc_bias = '0;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic signed [63:0] res_data;
    logic [10:0]        res_count;
    logic               controlArr, r_enable;
    logic [9:0]         init_i;
    logic signed [63:0] init_acc;
    logic               we_a, we_b;
    logic [9:0]         addr_a, addr_b;
    logic signed [26:0] wd_a, wd_b;
    logic               w_enable;
    logic signed [63:0] result;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    int cyc = 0, acc_cnt = 0, wr_cnt = 0, fill_cnt = 0, ren_cnt = 0, viol = 0;
    int last_acc_cyc = 0, ren_cyc = 0, wen_cyc = 0, rv_cyc = 0;
    logic [9:0] last_acc_addr = '0;
    logic rv_prev = 1'b0;

    always #5 clk = ~clk;

    dot_prod_host dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .acc_bias(acc_bias),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_count(res_count),
        .controlArr(controlArr), .r_enable(r_enable),
        .init_i(init_i), .init_acc(init_acc),
        .controlArrWEnable_a(we_a), .controlArrWEnable_b(we_b),
        .controlArrAddr_a(addr_a), .controlArrAddr_b(addr_b),
        .controlArrWData_a(wd_a), .controlArrWData_b(wd_b),
        .w_enable(w_enable), .result(result)
    );

    // Kernel model: arrays scrambled on reset, sums on r_enable, answers after a fixed delay.
    logic signed [26:0] mem_a [1000];
    logic signed [26:0] mem_b [1000];
    longint k_res;
    int     k_cnt;
    bit     k_pend;

    function automatic longint kern_sum(input longint start, input int first);
        longint s = start;
        for (int i = first; i < 1000; i++) s += longint'(mem_a[i]) * longint'(mem_b[i]);
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_enable <= 1'b0;
            result   <= '0;
            k_pend   <= 1'b0;
            k_cnt    <= 0;
            k_res    <= 0;
            for (int i = 0; i < 1000; i++) begin
                mem_a[i] <= 27'(1234 + i);
                mem_b[i] <= -27'sd77;
            end
        end else begin
            w_enable <= 1'b0;
            if (we_a) mem_a[addr_a] <= wd_a;
            if (we_b) mem_b[addr_b] <= wd_b;
            if (r_enable) begin
                k_res  <= kern_sum(init_acc, int'(init_i));
                k_pend <= 1'b1;
                k_cnt  <= 12;
            end else if (k_pend) begin
                if (k_cnt == 0) begin
                    w_enable <= 1'b1;
                    result   <= k_res;
                    k_pend   <= 1'b0;
                end else begin
                    k_cnt <= k_cnt - 1;
                end
            end
        end
    end

    // Mid-cycle monitor: event counters and port-discipline violations.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (in_valid && in_ready) begin
            acc_cnt       = acc_cnt + 1;
            last_acc_cyc  = cyc;
            last_acc_addr = addr_a;
        end
        if (we_a) wr_cnt = wr_cnt + 1;
        if (we_a && !(in_valid && in_ready)) fill_cnt = fill_cnt + 1;
        if (r_enable) begin
            ren_cnt = ren_cnt + 1;
            ren_cyc = cyc;
        end
        if (w_enable) wen_cyc = cyc;
        if (res_valid && !rv_prev) rv_cyc = cyc;
        rv_prev = res_valid;
        if (we_a !== we_b) viol = viol + 1;
        if (!controlArr && (we_a || we_b)) viol = viol + 1;
        if (!we_a && (addr_a != 0 || wd_a != 0)) viol = viol + 1;
        if (!we_b && (addr_b != 0 || wd_b != 0)) viol = viol + 1;
        if (we_a && addr_a !== addr_b) viol = viol + 1;
    end

    // Offers one pair; returns just after the accepting edge (or after the bound expires).
    task automatic push_pair(input logic signed [26:0] a, input logic signed [26:0] b,
                             input logic last, output bit ok);
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1; ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk); #1;
            if (ok) break;
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_res(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic ack();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        checks++; if (controlArr !== 1'b0 || r_enable !== 1'b0) begin errors++; $display("FAIL rst_ctrl: got ctrl=%b ren=%b want 0 0", controlArr, r_enable); end
        checks++; if (we_a !== 1'b0 || we_b !== 1'b0) begin errors++; $display("FAIL rst_we: got %b%b want 00", we_a, we_b); end
        checks++; if (res_valid !== 1'b0 || res_data !== 64'sd0 || res_count !== 11'd0) begin errors++; $display("FAIL rst_res: got v=%b d=%0d c=%0d want 0 0 0", res_valid, res_data, res_count); end
        checks++; if (init_i !== 10'd0 || init_acc !== 64'sd0) begin errors++; $display("FAIL rst_init: got i=%0d acc=%0d want 0 0", init_i, init_acc); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || controlArr !== 1'b1) begin errors++; $display("FAIL idle_out: got rdy=%b ctrl=%b want 1 1", in_ready, controlArr); end
    endtask

    task automatic test_basic();
        int f0 = fill_cnt, w0 = wr_cnt, r0 = ren_cnt, t0;
        bit ok, all_ok = 1'b1;
        exp_t e;
        acc_bias = 64'sd0;
        push_pair(27'sd1, 27'sd4, 1'b0, ok); all_ok &= ok; t0 = last_acc_cyc;
        acc_bias = 64'sd777;
        push_pair(27'sd2, 27'sd5, 1'b0, ok); all_ok &= ok;
        push_pair(27'sd3, 27'sd6, 1'b1, ok); all_ok &= ok;
        sb.push_back('{64'sd32, 3});
        wait_res(ok);
        checks++; if ((all_ok && ok) !== 1'b1) begin errors++; $display("FAIL basic_timeout: got load=%b res=%b want 1 1", all_ok, ok); end
        e = sb.pop_front();
        checks++; if (res_data !== e.data) begin errors++; $display("FAIL basic_data: got %0d want %0d", res_data, e.data); end
        checks++; if (res_count !== 11'(e.cnt)) begin errors++; $display("FAIL basic_count: got %0d want %0d", res_count, e.cnt); end
        checks++; if (fill_cnt - f0 !== 997 || wr_cnt - w0 !== 1000) begin errors++; $display("FAIL basic_fill: got fill=%0d wr=%0d want 997 1000", fill_cnt - f0, wr_cnt - w0); end
        checks++; if (ren_cnt - r0 !== 1) begin errors++; $display("FAIL basic_ren: got %0d pulses want 1", ren_cnt - r0); end
        checks++; if (ren_cyc - t0 !== 1000) begin errors++; $display("FAIL basic_latency: got %0d want 1000", ren_cyc - t0); end
        ack();
    endtask

    task automatic test_full();
        int f0 = fill_cnt, r0 = ren_cnt, t0 = 0;
        bit ok, all_ok = 1'b1;
        exp_t e;
        acc_bias = 64'sd10;
        for (int i = 0; i < 1000; i++) begin
            push_pair(27'sd1, -27'sd1, 1'b0, ok); all_ok &= ok;
            if (i == 0) t0 = last_acc_cyc;
        end
        sb.push_back('{-64'sd990, 1000});
        wait_res(ok);
        checks++; if ((all_ok && ok) !== 1'b1) begin errors++; $display("FAIL full_timeout: got load=%b res=%b want 1 1", all_ok, ok); end
        e = sb.pop_front();
        checks++; if (res_data !== e.data || res_count !== 11'(e.cnt)) begin errors++; $display("FAIL full_result: got %0d/%0d want %0d/%0d", res_data, res_count, e.data, e.cnt); end
        checks++; if (fill_cnt - f0 !== 0 || ren_cnt - r0 !== 1) begin errors++; $display("FAIL full_fill: got fill=%0d ren=%0d want 0 1", fill_cnt - f0, ren_cnt - r0); end
        checks++; if (ren_cyc - t0 !== 1000) begin errors++; $display("FAIL full_latency: got %0d want 1000", ren_cyc - t0); end
        ack();
    endtask

    task automatic test_last_at_end();
        int a0 = acc_cnt, f0 = fill_cnt;
        longint s = -5;
        bit ok, all_ok = 1'b1;
        exp_t e;
        acc_bias = -64'sd5;
        for (int i = 0; i < 1000; i++) begin
            s += longint'((i % 13) - 6) * longint'((i % 5) + 1);
            push_pair(27'((i % 13) - 6), 27'((i % 5) + 1), (i == 999), ok); all_ok &= ok;
        end
        sb.push_back('{s, 1000});
        wait_res(ok);
        checks++; if ((all_ok && ok) !== 1'b1) begin errors++; $display("FAIL last_timeout: got load=%b res=%b want 1 1", all_ok, ok); end
        e = sb.pop_front();
        checks++; if (res_data !== e.data || res_count !== 11'(e.cnt)) begin errors++; $display("FAIL last_result: got %0d/%0d want %0d/%0d", res_data, res_count, e.data, e.cnt); end
        checks++; if (acc_cnt - a0 !== 1000 || fill_cnt - f0 !== 0) begin errors++; $display("FAIL last_counts: got acc=%0d fill=%0d want 1000 0", acc_cnt - a0, fill_cnt - f0); end
        ack();
        repeat (3) @(negedge clk);
        checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL last_single_end: got v=%b rdy=%b want 0 1", res_valid, in_ready); end
    endtask

    task automatic test_single_hold();
        int f0 = fill_cnt;
        bit ok, bad = 1'b0;
        logic signed [63:0] d;
        exp_t e;
        acc_bias = -64'sd1;
        push_pair(-27'sd67108864, 27'sd67108863, 1'b1, ok);
        sb.push_back('{-(64'sd67108864 * 64'sd67108863) - 64'sd1, 1});
        wait_res(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_timeout: got %b want 1", ok); end
        e = sb.pop_front();
        checks++; if (res_data !== e.data || res_count !== 11'(e.cnt)) begin errors++; $display("FAIL single_result: got %0d/%0d want %0d/%0d", res_data, res_count, e.data, e.cnt); end
        checks++; if (fill_cnt - f0 !== 999) begin errors++; $display("FAIL single_fill: got %0d want 999", fill_cnt - f0); end
        checks++; if (rv_cyc - wen_cyc !== 1) begin errors++; $display("FAIL single_res_latency: got %0d want 1", rv_cyc - wen_cyc); end
        d = res_data;
        repeat (50) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== d || res_count !== 11'd1 || in_ready !== 1'b0) bad = 1'b1;
        end
        #1;
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL hold_stable: got unstable=%b want 0", bad); end
        ack();
    endtask

    task automatic test_reset_mid_run();
        int r0 = ren_cnt;
        bit ok;
        exp_t e;
        acc_bias = 64'sd3;
        for (int i = 0; i < 5; i++) push_pair(27'sd100, 27'sd100, (i == 4), ok);
        for (int k = 0; k < 3000 && ren_cnt == r0; k++) begin @(negedge clk); #1; end
        @(posedge clk); #1;
        checks++; if (ren_cnt - r0 !== 1 || res_valid !== 1'b0) begin errors++; $display("FAIL midrun_reach: got ren=%0d v=%b want 1 0", ren_cnt - r0, res_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0 || controlArr !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL midrun_async: got rdy=%b ctrl=%b v=%b want 0 0 0", in_ready, controlArr, res_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        acc_bias = 64'sd0;
        push_pair(27'sd7, 27'sd7, 1'b0, ok);
        push_pair(27'sd1, 27'sd1, 1'b1, ok);
        sb.push_back('{64'sd50, 2});
        wait_res(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL midrun_timeout: got %b want 1", ok); end
        e = sb.pop_front();
        checks++; if (res_data !== e.data || res_count !== 11'(e.cnt)) begin errors++; $display("FAIL midrun_result: got %0d/%0d want %0d/%0d", res_data, res_count, e.data, e.cnt); end
        ack();
    endtask

    task automatic test_back_to_back();
        int a0;
        bit ok, got = 1'b0;
        exp_t e;
        acc_bias = 64'sd1;
        push_pair(27'sd2, 27'sd3, 1'b0, ok);
        push_pair(27'sd4, 27'sd5, 1'b1, ok);
        sb.push_back('{64'sd27, 2});
        in_a = 27'sd9; in_b = 27'sd9; in_last = 1'b1; in_valid = 1'b1; acc_bias = 64'sd100;
        sb.push_back('{64'sd181, 1});
        a0 = acc_cnt;
        wait_res(ok);
        checks++; if (acc_cnt - a0 !== 0) begin errors++; $display("FAIL b2b_blocked: got %0d accepts want 0", acc_cnt - a0); end
        e = sb.pop_front();
        checks++; if (res_data !== e.data || res_count !== 11'(e.cnt)) begin errors++; $display("FAIL b2b_first: got %0d/%0d want %0d/%0d", res_data, res_count, e.data, e.cnt); end
        ack();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            if (acc_cnt > a0) begin got = 1'b1; break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (got !== 1'b1 || last_acc_addr !== 10'd0) begin errors++; $display("FAIL b2b_addr0: got acc=%b addr=%0d want 1 0", got, last_acc_addr); end
        wait_res(ok);
        e = sb.pop_front();
        checks++; if (ok !== 1'b1 || res_data !== e.data || res_count !== 11'(e.cnt)) begin errors++; $display("FAIL b2b_second: got %0d/%0d want %0d/%0d", res_data, res_count, e.data, e.cnt); end
        ack();
        checks++; if (viol !== 0 || sb.size() !== 0) begin errors++; $display("FAIL port_discipline: got viol=%0d sb=%0d want 0 0", viol, sb.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_last_at_end();
        test_single_hold();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dot_prod_host.md
DOT_PROD_HOST -- requirements
Module: dot_prod_host

Interface
REQ-001 Parameters SHALL be: ARR_LEN, 1000, array depth; ADDR_W, 10, address width; ELEM_W, 27, signed element width; ACC_W, 64, signed accumulator width.
REQ-002 Clock and reset SHALL be: clk, rst_n. The block has one clock; rst_n is asynchronous and active-low.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 in_valid / in_ready  in / out  1 / 1  element-pair stream handshake.
REQ-006 in_a, in_b  in  ELEM_W each  signed element pair.
REQ-007 in_last  in  1  marks the final pair of a vector.
REQ-008 acc_bias  in  ACC_W  signed initial accumulator, sampled on the first accepted pair.
REQ-009 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-010 res_data  out  ACC_W  signed dot product plus bias.
REQ-011 res_count  out  11  number of pairs loaded, 1..1000.
REQ-012 controlArr, r_enable  out  1 each  kernel array-ownership and start strobe.
REQ-013 init_i  out  ADDR_W  kernel start index.
REQ-014 init_acc  out  ACC_W  kernel start accumulator.
REQ-015 controlArrWEnable_a/_b  out  1  array write enables.
REQ-016 controlArrAddr_a/_b  out  ADDR_W  array addresses.
REQ-017 controlArrWData_a/_b  out  ELEM_W  array write data.
REQ-018 w_enable  in  1  kernel done.
REQ-019 result  in  ACC_W  kernel result.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, FILL, START, RUN, HOLD; reset state IDLE.
REQ-021 IDLE/LOAD: in_ready=1 and controlArr=1; an accepted pair SHALL write in_a/in_b to addr=idx in the same cycle (both write enables 1); idx increments.
REQ-022 IDLE moves to LOAD on the first accepted pair; acc_bias is latched on that pair.
REQ-023 An accepted pair with in_last=1, or the pair written at idx=999, SHALL end loading; the count is latched as idx+1.
REQ-024 After loading: if count<1000, go to FILL; otherwise go to START.
REQ-025 FILL: in_ready=0, controlArr=1; write 0 to both arrays at idx..999, one address per cycle; go to START after address 999.
REQ-026 START: one cycle with controlArr=0, r_enable=1, init_i=0, init_acc=latched bias; all write enables 0.
REQ-027 RUN: r_enable=0; wait for w_enable=1, then capture result into res_data and go to HOLD.
REQ-028 HOLD: res_valid=1; res_data and res_count SHALL be stable until res_ready; on handshake go to IDLE with idx=0.
REQ-029 Pairs offered outside IDLE/LOAD SHALL NOT be accepted.
REQ-030 in_last arriving on the idx=999 pair SHALL be treated as a single end of vector.
REQ-031 Write enables SHALL be 0 whenever controlArr=0.
REQ-032 Address and write data SHALL be 0 when not writing.
REQ-033 Latency: count + (1000−count) + 1 cycles to r_enable; the result appears the cycle after w_enable is sampled high.

Reset
REQ-034 On rst_n low, asynchronously: state=IDLE, idx=0, in_ready=0, controlArr=0, r_enable=0, all write enables 0, res_valid=0, res_data=0, res_count=0, init_i=0, init_acc=0.
REQ-035 Reset mid-RUN SHALL abandon the kernel run; the next vector reloads all 1000 addresses, so stale array contents have no effect.

Structure
REQ-036 Package dot_prod_pkg SHALL hold ARR_LEN, ADDR_W, ELEM_W, ACC_W and the state enum; the kernel and host share it.
REQ-037 There SHALL be no sub-module; the host connects to the kernel at the top level and does not instantiate it.

Verification
REQ-038 Three pairs (1,4), (2,5), (3,6) with last, bias 0 -> 997 FILL writes, one r_enable pulse, res_data=32, res_count=3.
REQ-039 1000 pairs a=1, b=−1, no in_last, bias 10 -> no FILL cycles, res_data=−990, res_count=1000.
REQ-040 Single pair (−2^26, 2^26−1), last, bias −1 -> res_data=−2^26·(2^26−1)−1, res_count=1.
REQ-041 res_ready held 0 for 50 cycles in HOLD -> res_valid and res_data constant; in_ready=0 throughout.
REQ-042 rst_n pulsed low during RUN, then two pairs (7,7), (1,1) with last -> res_data=50; the earlier vector does not leak.
REQ-043 in_valid held high across HOLD -> no pair accepted until the result handshake completes; the next pair is written at address 0.
